// File: rtl/dbg_scan_ctrl_if.sv
// rtl/dbg_scan_ctrl_if.sv - debug sweeper configuration, debug-bus and capture-FIFO signal bundle
interface dbg_scan_ctrl_if #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int DWELL_W = 8
) ();
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                     start;
  logic [ADDR_W-1:0]        cfg_first;
  logic [ADDR_W-1:0]        cfg_last;
  logic [DWELL_W-1:0]       cfg_dwell;
  logic                     cfg_src;
  logic [ADDR_W-1:0]        m_rf_addr;
  logic [DATA_W-1:0]        rf_data;
  logic [DATA_W-1:0]        m_data;
  logic                     busy;
  logic                     done;
  logic                     rd_en;
  logic [ADDR_W+DATA_W-1:0] rd_data;
  logic                     empty;
  logic                     full;
  logic [CNT_W-1:0]         count;
  logic                     overflow;

  // The sweeper itself
  modport slave (
    input  start, cfg_first, cfg_last, cfg_dwell, cfg_src, rf_data, m_data, rd_en,
    output m_rf_addr, busy, done, rd_data, empty, full, count, overflow
  );

  // Whoever configures the sweep, serves the debug port and drains the FIFO
  modport master (
    output start, cfg_first, cfg_last, cfg_dwell, cfg_src, rf_data, m_data, rd_en,
    input  m_rf_addr, busy, done, rd_data, empty, full, count, overflow
  );
endinterface

// File: rtl/dbg_scan_ctrl.sv
// rtl/dbg_scan_ctrl.sv - debug-bus address sweeper with capture FIFO; DBG_SCAN_DROP_EN selects drop-on-full instead of stall
module dbg_scan_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int DWELL_W = 8
) (
  input logic          clk,
  input logic          rst,
  dbg_scan_ctrl_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  last_q, last_d;
  logic [DWELL_W-1:0] dwell_cfg_q, dwell_cfg_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               src_q, src_d;

  logic [ENT_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic               fifo_full, fifo_empty, pop, push_ok, do_push;
  logic               capture, advance, at_last, accept_start;
  logic [DATA_W-1:0]  src_data;

  assign fifo_full    = (count_q == CNT_W'(DEPTH));
  assign fifo_empty   = (count_q == '0);
  assign pop          = bus.rd_en && !fifo_empty;
  assign push_ok      = !fifo_full || pop;
  // SETTLE captures once the dwell has run out; HOLD retries every cycle
  assign capture      = ((state_q == S_SETTLE) && (dwell_q == '0)) || (state_q == S_HOLD);
  assign do_push      = capture && push_ok;
  assign at_last      = (addr_q == last_q);
  // DONE already has busy low, so a start there is honoured as in IDLE
  assign accept_start = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign src_data     = src_q ? bus.m_data : bus.rf_data;

`ifdef DBG_SCAN_DROP_EN
  // A blocked sample is discarded and the sweep carries on
  assign advance = capture;
`else
  assign advance = do_push;
`endif

  // State and sweep datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      last_q      <= '0;
      dwell_cfg_q <= '0;
      dwell_q     <= '0;
      src_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_q      <= last_d;
      dwell_cfg_q <= dwell_cfg_d;
      dwell_q     <= dwell_d;
      src_q       <= src_d;
    end
  end

  // Next-state logic for the sweep FSM and its datapath
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    last_d      = last_q;
    dwell_cfg_d = dwell_cfg_q;
    dwell_d     = dwell_q;
    src_d       = src_q;
    case (state_q)
      S_IDLE, S_DONE: state_d = accept_start ? S_SETTLE : S_IDLE;
      S_SETTLE, S_HOLD: begin
        if (advance)      state_d = at_last ? S_DONE : S_SETTLE;
        else if (capture) state_d = S_HOLD;
      end
      default: state_d = S_IDLE;
    endcase
    if (accept_start) begin
      addr_d      = bus.cfg_first;
      last_d      = bus.cfg_last;
      dwell_cfg_d = bus.cfg_dwell;
      dwell_d     = bus.cfg_dwell;
      src_d       = bus.cfg_src;
    end else if ((state_q == S_SETTLE) && (dwell_q != '0)) begin
      dwell_d = dwell_q - DWELL_W'(1);
    end else if (advance && !at_last) begin
      addr_d  = addr_q + ADDR_W'(1);
      dwell_d = dwell_cfg_q;
    end
  end

  // Status outputs decoded from the current state
  always_comb begin
    bus.busy = (state_q == S_SETTLE) || (state_q == S_HOLD);
    bus.done = (state_q == S_DONE);
  end

  // Capture storage; contents are only visible through the occupancy-gated head
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= {addr_q, src_data};
  end

  // FIFO pointers and occupancy; a simultaneous push and pop keeps the count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef DBG_SCAN_DROP_EN
  logic overflow_q;

  // Sticky record that at least one sample was dropped
  always_ff @(posedge clk) begin
    if (rst)                       overflow_q <= 1'b0;
    else if (capture && !push_ok)  overflow_q <= 1'b1;
  end

  assign bus.overflow = overflow_q;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.m_rf_addr = addr_q;
  assign bus.rd_data   = fifo_empty ? '0 : mem[rd_ptr_q];
  assign bus.empty     = fifo_empty;
  assign bus.full      = fifo_full;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_dbg_scan_ctrl.sv
// tb/tb_dbg_scan_ctrl.sv - directed table-driven bench for dbg_scan_ctrl
module tb_dbg_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cnt = 0;

  dbg_scan_ctrl_if #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .DWELL_W(8)) bus ();

  dbg_scan_ctrl #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .DWELL_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Debug read port model: combinational from the address
  assign bus.rf_data = {24'h0, bus.m_rf_addr};
  assign bus.m_data  = {16'hC0DE, 8'h00, bus.m_rf_addr};

  always @(posedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

  typedef struct {
    logic [7:0] first;
    logic [7:0] last;
    logic [7:0] dwell;
    logic       src;
    int         n;
    int         lat;
    int         busy;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] exp_entry(input logic [7:0] a, input logic src);
    return {a, (src ? {16'hC0DE, 8'h00, a} : {24'h0, a})};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b0;
    bus.rd_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pop1();
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic do_sweep(input logic [7:0] first, input logic [7:0] last, input logic [7:0] dwell,
                          input logic src, output int lat, output int busy_n, output int hold_first);
    @(negedge clk);
    bus.cfg_first = first;
    bus.cfg_last  = last;
    bus.cfg_dwell = dwell;
    bus.cfg_src   = src;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    lat        = 0;
    busy_n     = 0;
    hold_first = 0;
    for (int c = 1; c <= 2000; c++) begin
      if (bus.done === 1'b1) begin
        lat = c;
        break;
      end
      if (bus.busy === 1'b1) busy_n++;
      if (bus.busy === 1'b1 && bus.m_rf_addr == first) hold_first++;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int base, input int limit);
    for (int c = 0; c < limit && done_cnt == base; c++) @(negedge clk);
    check("done_within_bound", 64'(done_cnt - base), 64'd1);
  endtask

  initial begin
    int lat, busy_n, hold_first, base;
    bus.start = 1'b0; bus.rd_en = 1'b0;
    bus.cfg_first = '0; bus.cfg_last = '0; bus.cfg_dwell = '0; bus.cfg_src = 1'b0;

    //           first  last   dwell src n  lat busy
    vecs[0] = '{8'h01, 8'h04, 8'd0, 0, 4, 5, 4};
    vecs[1] = '{8'h10, 8'h11, 8'd3, 0, 2, 9, 8};
    vecs[2] = '{8'hFE, 8'h01, 8'd0, 1, 4, 5, 4};
    vecs[3] = '{8'h07, 8'h07, 8'd2, 1, 1, 4, 3};
    vecs[4] = '{8'h30, 8'h32, 8'd1, 0, 3, 7, 6};

    do_reset();
    check("rst_addr",     64'(bus.m_rf_addr), 64'd0);
    check("rst_busy",     64'(bus.busy),      64'd0);
    check("rst_done",     64'(bus.done),      64'd0);
    check("rst_empty",    64'(bus.empty),     64'd1);
    check("rst_full",     64'(bus.full),      64'd0);
    check("rst_count",    64'(bus.count),     64'd0);
    check("rst_overflow", 64'(bus.overflow),  64'd0);
    check("rst_rd_data",  64'(bus.rd_data),   64'd0);

    for (int v = 0; v < 5; v++) begin
      do_sweep(vecs[v].first, vecs[v].last, vecs[v].dwell, vecs[v].src, lat, busy_n, hold_first);
      check($sformatf("v%0d_done_latency", v), 64'(lat), 64'(vecs[v].lat));
      check($sformatf("v%0d_busy_cycles", v), 64'(busy_n), 64'(vecs[v].busy));
      check($sformatf("v%0d_first_addr_cycles", v), 64'(hold_first), 64'(vecs[v].dwell) + 64'd1);
      check($sformatf("v%0d_busy_at_done", v), 64'(bus.busy), 64'd0);
      check($sformatf("v%0d_count", v), 64'(bus.count), 64'(vecs[v].n));
      for (int i = 0; i < vecs[v].n; i++) begin
        check($sformatf("v%0d_entry%0d", v, i), 64'(bus.rd_data),
              64'(exp_entry(vecs[v].first + 8'(i), vecs[v].src)));
        pop1();
      end
      check($sformatf("v%0d_drained", v), 64'(bus.empty), 64'd1);
    end

    // Reset in the middle of a sweep
    do_reset();
    base = done_cnt;
    bus.cfg_first = 8'h01; bus.cfg_last = 8'h08; bus.cfg_dwell = 8'd2; bus.cfg_src = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 100 && bus.m_rf_addr != 8'h03; c++) @(negedge clk);
    check("mid_addr_reached", 64'(bus.m_rf_addr), 64'h03);
    check("mid_count_before", 64'(bus.count), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_busy", 64'(bus.busy), 64'd0);
    check("mid_count", 64'(bus.count), 64'd0);
    check("mid_addr", 64'(bus.m_rf_addr), 64'd0);
    repeat (15) @(negedge clk);
    check("mid_no_done", 64'(done_cnt - base), 64'd0);

    // Start while busy must be ignored
    base = done_cnt;
    bus.cfg_first = 8'h20; bus.cfg_last = 8'h23; bus.cfg_dwell = 8'd1; bus.cfg_src = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.cfg_first = 8'h80; bus.cfg_last = 8'h80; bus.cfg_dwell = 8'd0; bus.cfg_src = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(base, 40);
    repeat (6) @(negedge clk);
    check("sb_done_pulses", 64'(done_cnt - base), 64'd1);
    check("sb_count", 64'(bus.count), 64'd4);
    check("sb_head", 64'(bus.rd_data), 64'(exp_entry(8'h20, 1'b0)));
    check("sb_last_addr", 64'(bus.m_rf_addr), 64'h23);

    // 20-address sweep into a 16-entry FIFO with no reads
    do_reset();
`ifdef DBG_SCAN_DROP_EN
    do_sweep(8'h40, 8'h53, 8'd0, 1'b0, lat, busy_n, hold_first);
    check("drop_latency", 64'(lat), 64'd21);
    check("drop_count", 64'(bus.count), 64'd16);
    check("drop_overflow", 64'(bus.overflow), 64'd1);
    check("drop_head", 64'(bus.rd_data), 64'(exp_entry(8'h40, 1'b0)));
    @(negedge clk);
`else
    base = done_cnt;
    bus.cfg_first = 8'h40; bus.cfg_last = 8'h53; bus.cfg_dwell = 8'd0; bus.cfg_src = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (25) @(negedge clk);
    check("stall_busy", 64'(bus.busy), 64'd1);
    check("stall_count", 64'(bus.count), 64'd16);
    check("stall_full", 64'(bus.full), 64'd1);
    check("stall_addr", 64'(bus.m_rf_addr), 64'h50);
    check("stall_no_done", 64'(done_cnt - base), 64'd0);
    check("stall_overflow", 64'(bus.overflow), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall_pop%0d_head", i), 64'(bus.rd_data), 64'(exp_entry(8'h40 + 8'(i), 1'b0)));
      pop1();
      check($sformatf("stall_pop%0d_count", i), 64'(bus.count), 64'd16);
      @(negedge clk);
    end
    wait_done(base, 20);
    check("stall_final_count", 64'(bus.count), 64'd16);
    check("stall_final_head", 64'(bus.rd_data), 64'(exp_entry(8'h44, 1'b0)));
`endif

    // Push and pop on the same edge while full
    base = done_cnt;
    bus.cfg_first = 8'h60; bus.cfg_last = 8'h60; bus.cfg_dwell = 8'd0; bus.cfg_src = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    check("pp_count", 64'(bus.count), 64'd16);
    check("pp_done", 64'(bus.done), 64'd1);
`ifdef DBG_SCAN_DROP_EN
    check("pp_head", 64'(bus.rd_data), 64'(exp_entry(8'h41, 1'b0)));
`else
    check("pp_head", 64'(bus.rd_data), 64'(exp_entry(8'h45, 1'b0)));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
